// File: rtl/shifter_seq.sv
// Multi-cycle shifter: moves the operand by at most STEP bits per clock
// (SRL, SLL, SRA, ROR) behind a start/busy/done handshake.
module shifter_seq #(
  parameter  int W    = 32,
  parameter  int STEP = 1,
  localparam int SW   = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  y
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0]    M_SRL  = 2'b00;
  localparam logic [1:0]    M_SLL  = 2'b01;
  localparam logic [1:0]    M_SRA  = 2'b10;
  localparam logic [SW-1:0] STEP_C = SW'(STEP);
  localparam int            NCAND  = 2 ** SW;

  state_t        state_reg, state_next;
  logic [W-1:0]  work_reg,  work_next;
  logic [SW-1:0] rem_reg,   rem_next;
  logic [1:0]    mode_reg,  mode_next;
  logic [W-1:0]  y_reg,     y_next;

  logic [SW-1:0] k;
  logic [W-1:0]  stepped;
  logic [W-1:0]  cand [NCAND];

  // One candidate per possible step size; entries beyond STEP are never
  // selected and just mirror the work register so the mux index is full width.
  genvar gi;
  generate
    for (gi = 0; gi < NCAND; gi++) begin : g_cand
      if (gi == 0 || gi > STEP) begin : g_pass
        assign cand[gi] = work_reg;
      end else begin : g_shift
        logic [2*W-1:0] dbl;
        assign dbl = {work_reg, work_reg} >> gi;
        always_comb begin
          case (mode_reg)
            M_SRL:   cand[gi] = work_reg >> gi;
            M_SLL:   cand[gi] = work_reg << gi;
            M_SRA:   cand[gi] = W'($signed(work_reg) >>> gi);
            default: cand[gi] = dbl[W-1:0];
          endcase
        end
      end
    end
  endgenerate

  assign k       = (rem_reg > STEP_C) ? STEP_C : rem_reg;
  assign stepped = cand[k];

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    rem_next   = rem_reg;
    mode_next  = mode_reg;
    y_next     = y_reg;
    case (state_reg)
      SHIFT: begin
        work_next = stepped;
        rem_next  = rem_reg - k;
        if (rem_reg == k) begin
          y_next     = stepped;
          state_next = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        state_next = IDLE;
        if (start) begin
          work_next = a;
          rem_next  = shamt;
          mode_next = mode;
          if (shamt == '0) begin
            y_next     = a;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      rem_reg   <= '0;
      mode_reg  <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      rem_reg   <= rem_next;
      mode_reg  <= mode_next;
      y_reg     <= y_next;
    end
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign y    = y_reg;

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq across several W/STEP configurations,
// compared against an arithmetic shift model and the latency formula.
module tb_shifter_seq;

  localparam int NDUT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [NDUT];
  logic [31:0] a_in = '0;
  logic [4:0]  shamt_in = '0;
  logic [1:0]  mode_in = '0;
  logic        busy_v [NDUT];
  logic        done_v [NDUT];
  logic [31:0] y_v [NDUT];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic int width_of(int i);
    return (i == 4) ? 32 : 8;
  endfunction

  function automatic int step_of(int i);
    case (i)
      0: return 1;
      1: return 3;
      2: return 4;
      3: return 7;
      default: return 4;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int WW  = (gi == 4) ? 32 : 8;
      localparam int SS  = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : (gi == 3) ? 7 : 4;
      localparam int SWW = $clog2(WW);
      logic [WW-1:0] y_o;
      shifter_seq #(.W(WW), .STEP(SS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_v[gi]),
        .a     (a_in[WW-1:0]),
        .shamt (shamt_in[SWW-1:0]),
        .mode  (mode_in),
        .busy  (busy_v[gi]),
        .done  (done_v[gi]),
        .y     (y_o)
      );
      assign y_v[gi] = 32'(y_o);
    end
  endgenerate

  // Reference: whole-amount shift computed with 64-bit arithmetic and masks.
  function automatic logic [31:0] model(logic [31:0] av, int s, logic [1:0] m, int w);
    logic [63:0] mask, x, r;
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, av} & mask;
    case (m)
      2'b00: r = x >> s;
      2'b01: r = (x << s) & mask;
      2'b10: r = (x >> s) | ((x[w-1]) ? (mask & ~(mask >> s)) : 64'd0);
      default: r = ((x >> s) | (x << (w - s))) & mask;
    endcase
    return r[31:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Launch one operation on DUT sel and check result, latency, busy count and y hold.
  task automatic run_op(int sel, logic [31:0] av, int s, logic [1:0] m, logic [31:0] yexp);
    int lat, nbusy, viol, st, expl;
    logic [31:0] ypre;
    st    = step_of(sel);
    expl  = 1 + (s + st - 1) / st;
    lat   = 0;
    nbusy = 0;
    viol  = 0;
    @(negedge clk);
    ypre         = y_v[sel];
    a_in         = av;
    shamt_in     = 5'(s);
    mode_in      = m;
    start_v[sel] = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start_v[sel] = 1'b0;
        a_in         = $urandom;
        shamt_in     = 5'($urandom);
        mode_in      = 2'($urandom);
      end
      if (done_v[sel]) begin
        lat = cyc;
        break;
      end
      if (busy_v[sel]) nbusy++;
      if (y_v[sel] !== ypre) viol++;
    end
    $display("op dut=%0d a=%h shamt=%0d mode=%0d y=%h exp=%h lat=%0d", sel, av, s, m, y_v[sel], yexp, lat);
    chk("y", y_v[sel], yexp);
    chk("latency", 32'(lat), 32'(expl));
    chk("busy_cycles", 32'(nbusy), 32'(expl - 1));
    chk("y_hold", 32'(viol), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done_v[sel]), 32'd0);
  endtask

  initial begin
    int ndone;
    for (int i = 0; i < NDUT; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_busy", 32'(busy_v[i]), 32'd0);
      chk("rst_done", 32'(done_v[i]), 32'd0);
      chk("rst_y", y_v[i], 32'd0);
    end
    rst_n = 1'b1;

    // W=8 STEP=1 directed operations on 8'hB4
    run_op(0, 32'hB4, 3, 2'b00, 32'h16);
    run_op(0, 32'hB4, 3, 2'b01, 32'hA0);
    run_op(0, 32'hB4, 3, 2'b10, 32'hF6);
    run_op(0, 32'hB4, 3, 2'b11, 32'h96);
    // W=32 STEP=4, shamt 31 with a final partial step
    run_op(4, 32'h8000_0001, 31, 2'b10, 32'hFFFF_FFFF);
    run_op(4, 32'h8000_0001, 31, 2'b11, 32'h0000_0003);
    // Zero shift amount
    run_op(0, 32'h5A, 0, 2'b10, 32'h5A);
    run_op(0, 32'h5A, 0, 2'b11, 32'h5A);

    // Start ignored while busy, then accepted in DONE
    @(negedge clk);
    a_in = 32'hB4; shamt_in = 5'd3; mode_in = 2'b00; start_v[0] = 1'b1;
    @(negedge clk);
    a_in = 32'hFF;
    chk("b2b_busy1", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    a_in = 32'h80; shamt_in = 5'd1; mode_in = 2'b10;
    chk("b2b_busy3", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    chk("b2b_done1", 32'(done_v[0]), 32'd1);
    chk("b2b_y1", y_v[0], 32'h16);
    $display("b2b first y=%h", y_v[0]);
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_busy5", 32'(busy_v[0]), 32'd1);
    chk("b2b_nodone5", 32'(done_v[0]), 32'd0);
    @(negedge clk);
    chk("b2b_done2", 32'(done_v[0]), 32'd1);
    chk("b2b_y2", y_v[0], 32'hC0);
    $display("b2b second y=%h", y_v[0]);
    @(negedge clk);

    // Asynchronous reset during the second SHIFT cycle
    a_in = 32'hB4; shamt_in = 5'd3; mode_in = 2'b00; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_v[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_v[0]), 32'd0);
    chk("arst_done", 32'(done_v[0]), 32'd0);
    chk("arst_y", y_v[0], 32'd0);
    $display("async reset busy=%0d done=%0d y=%h", busy_v[0], done_v[0], y_v[0]);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) ndone++;
    end
    chk("post_rst_quiet", 32'(ndone), 32'd0);
    run_op(0, 32'hB4, 3, 2'b11, 32'h96);

    // Randomised operations on every configuration
    for (int sel = 0; sel < NDUT; sel++) begin
      for (int n = 0; n < 30; n++) begin
        logic [31:0] av;
        int s, w;
        logic [1:0] m;
        w  = width_of(sel);
        av = $urandom;
        if (w < 32) av = av & ((32'd1 << w) - 32'd1);
        s  = (n == 0) ? (w - 1) : int'($urandom_range(0, w - 1));
        m  = 2'($urandom);
        run_op(sel, av, s, m, model(av, s, m, w));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
